// File: rtl/key_pkg.sv
// Shared constants and helpers for the 8-key debounce front end that feeds the
// 8-to-3 priority encoder.
package key_pkg;

    localparam int unsigned NUM_KEYS = 8;

    // Keys are active-low all the way through to the encoder's iData.
    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    // Stability windows: short for simulation, ~10 ms at 100 MHz on the board.
    localparam int unsigned DEBOUNCE_CYCLES_SIM   = 4;
    localparam int unsigned DEBOUNCE_CYCLES_BOARD = 1000000;

    // Classify an accepted change of a debounced key level.
    function automatic logic isPressEdge(input logic prevLevel, input logic nextLevel);
        return (prevLevel == KEY_RELEASED) && (nextLevel == KEY_PRESSED);
    endfunction

    function automatic logic isReleaseEdge(input logic prevLevel, input logic nextLevel);
        return (prevLevel == KEY_PRESSED) && (nextLevel == KEY_RELEASED);
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One key: 2-FF synchronizer, stability counter, debounced level and
// registered press/release pulses.
module key_debounce_bit
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iKey,
    input  logic iPulseEn,
    output logic oKey,
    output logic oPress,
    output logic oRelease
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] stableCnt;
    logic             mismatch;
    logic             accept;

    // Only sync2 is used downstream; sync1 may be metastable.
    assign mismatch = (sync2 != oKey);
    assign accept   = mismatch && (stableCnt == CNT_LAST);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync1     <= KEY_RELEASED;
            sync2     <= KEY_RELEASED;
            stableCnt <= CNT_ZERO;
            oKey      <= KEY_RELEASED;
            oPress    <= 1'b0;
            oRelease  <= 1'b0;
        end else begin
            sync1    <= iKey;
            sync2    <= sync1;
            oPress   <= 1'b0;
            oRelease <= 1'b0;

            // Any matching sample restarts the window, so bounces never accumulate.
            if (!mismatch) begin
                stableCnt <= CNT_ZERO;
            end else if (!accept) begin
                stableCnt <= stableCnt + CNT_ONE;
            end else begin
                stableCnt <= CNT_ZERO;
                oKey      <= sync2;
                oPress    <= iPulseEn && isPressEdge(oKey, sync2);
                oRelease  <= iPulseEn && isReleaseEdge(oKey, sync2);
            end
        end
    end

endmodule

// File: rtl/key_debounce8.sv
// Eight independent debounced keys plus the active-low encoder enable,
// wired straight into the downstream priority encoder.
module key_debounce8
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [NUM_KEYS-1:0] iKeys,
    input  logic                iEn,
    output logic [NUM_KEYS-1:0] oKeys,
    output logic                oEI,
    output logic [NUM_KEYS-1:0] oPress,
    output logic [NUM_KEYS-1:0] oRelease
);

    // Pulses are gated by iEn on the accepting edge; the levels always track.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : genKey
        key_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) uBit (
            .iClk     (iClk),
            .iRst     (iRst),
            .iKey     (iKeys[k]),
            .iPulseEn (iEn),
            .oKey     (oKeys[k]),
            .oPress   (oPress[k]),
            .oRelease (oRelease[k])
        );
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oEI <= 1'b1;
        end else begin
            oEI <= ~iEn;
        end
    end

endmodule

// File: tb/tb_key_debounce8.sv
// Directed bench for key_debounce8: window of 4 on the main instance and a
// window of 1 on a second instance sharing the same stimulus.
module tb_key_debounce8;

    logic       iClk;
    logic       iRst;
    logic [7:0] iKeys;
    logic       iEn;
    logic [7:0] oKeys;
    logic       oEI;
    logic [7:0] oPress;
    logic [7:0] oRelease;
    logic [7:0] fKeys;
    logic       fEI;
    logic [7:0] fPress;
    logic [7:0] fRelease;

    int nChecks = 0;
    int nFails  = 0;

    key_debounce8 #(.DEBOUNCE_CYCLES(4)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iKeys    (iKeys),
        .iEn      (iEn),
        .oKeys    (oKeys),
        .oEI      (oEI),
        .oPress   (oPress),
        .oRelease (oRelease)
    );

    key_debounce8 #(.DEBOUNCE_CYCLES(1)) dutFast (
        .iClk     (iClk),
        .iRst     (iRst),
        .iKeys    (iKeys),
        .iEn      (iEn),
        .oKeys    (fKeys),
        .oEI      (fEI),
        .oPress   (fPress),
        .oRelease (fRelease)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic ticks(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    initial begin
        iRst  = 1'b1;
        iKeys = 8'hFF;
        iEn   = 1'b1;
        ticks(2);
        chk("rstKeys", oKeys, 8'hFF);
        chk("rstPress", oPress, 8'h00);
        chk("rstRelease", oRelease, 8'h00);
        chk("rstEI", {7'd0, oEI}, 8'h01);
        iRst = 1'b0;

        // All keys down, accepted well before the mid-cycle reset.
        iKeys = 8'h00;
        ticks(10);
        chk("allDownKeys", oKeys, 8'h00);
        chk("allDownEI", {7'd0, oEI}, 8'h00);

        #2;
        iRst = 1'b1;
        #1;
        chk("asyncRstKeys", oKeys, 8'hFF);
        chk("asyncRstPress", oPress, 8'h00);
        chk("asyncRstRelease", oRelease, 8'h00);
        chk("asyncRstEI", {7'd0, oEI}, 8'h01);
        ticks(1);
        iRst = 1'b0;

        // Held keys re-accepted on the 6th edge after deassert.
        ticks(1);
        chk("postRstEI", {7'd0, oEI}, 8'h00);
        ticks(4);
        chk("postRstEarly", oKeys, 8'hFF);
        ticks(1);
        chk("postRstKeys", oKeys, 8'h00);
        chk("postRstPress", oPress, 8'hFF);
        ticks(1);
        chk("postRstPressEnd", oPress, 8'h00);

        // Release everything.
        iKeys = 8'hFF;
        ticks(5);
        chk("relAllEarly", oKeys, 8'h00);
        ticks(1);
        chk("relAllKeys", oKeys, 8'hFF);
        chk("relAllPulse", oRelease, 8'hFF);
        ticks(1);
        chk("relAllPulseEnd", oRelease, 8'h00);

        // Clean press of key 3; fast instance accepts on the 3rd edge.
        iKeys = 8'hF7;
        ticks(2);
        chk("fastEarly", fKeys, 8'hFF);
        ticks(1);
        chk("fastKeys", fKeys, 8'hF7);
        chk("fastPress", fPress, 8'h08);
        ticks(2);
        chk("pressEarly", oKeys, 8'hFF);
        chk("pressEarlyPulse", oPress, 8'h00);
        ticks(1);
        chk("pressKeys", oKeys, 8'hF7);
        chk("pressPulse", oPress, 8'h08);
        ticks(1);
        chk("pressPulseEnd", oPress, 8'h00);
        chk("pressHold", oKeys, 8'hF7);
        iKeys = 8'hFF;
        ticks(8);
        chk("pressRelKeys", oKeys, 8'hFF);

        // Key 5 bounces with 3-cycle runs, then settles low.
        for (int b = 0; b < 4; b++) begin
            iKeys = (b % 2 == 0) ? 8'hDF : 8'hFF;
            ticks(3);
            chk("bounceKeys", oKeys, 8'hFF);
            chk("bouncePress", oPress, 8'h00);
        end
        iKeys = 8'hDF;
        ticks(5);
        chk("bounceEarly", oKeys, 8'hFF);
        ticks(1);
        chk("bounceKeys", oKeys, 8'hDF);
        chk("bouncePulse", oPress, 8'h20);
        ticks(1);
        chk("bouncePulseEnd", oPress, 8'h00);
        iKeys = 8'hFF;
        ticks(8);
        chk("bounceRelKeys", oKeys, 8'hFF);

        // Disabled: level updates, no pulse; enable later gives no late pulse.
        iEn = 1'b0;
        ticks(1);
        chk("disEI", {7'd0, oEI}, 8'h01);
        iKeys = 8'hFE;
        ticks(5);
        chk("disEarly", oKeys, 8'hFF);
        ticks(1);
        chk("disKeys", oKeys, 8'hFE);
        chk("disPress", oPress, 8'h00);
        chk("disEIHeld", {7'd0, oEI}, 8'h01);
        iEn = 1'b1;
        ticks(1);
        chk("enEI", {7'd0, oEI}, 8'h00);
        chk("enNoPress", oPress, 8'h00);
        ticks(1);
        chk("enNoPress2", oPress, 8'h00);
        iKeys = 8'hFF;
        ticks(6);
        chk("enRelPulse", oRelease, 8'h01);
        chk("enRelKeys", oKeys, 8'hFF);

        // Keys 1 and 6 together, then key 1 released alone.
        ticks(2);
        iKeys = 8'hBD;
        ticks(5);
        chk("simEarly", oPress, 8'h00);
        ticks(1);
        chk("simKeys", oKeys, 8'hBD);
        chk("simPress", oPress, 8'h42);
        ticks(1);
        chk("simPressEnd", oPress, 8'h00);
        ticks(14);
        iKeys = 8'hBF;
        ticks(5);
        chk("simRelEarly", oRelease, 8'h00);
        ticks(1);
        chk("simRelPulse", oRelease, 8'h02);
        chk("simRelKeys", oKeys, 8'hBF);
        ticks(1);
        chk("simRelPulseEnd", oRelease, 8'h00);
        chk("simRelHold", oKeys, 8'hBF);
        iKeys = 8'hFF;
        ticks(8);
        chk("simRelAll", oKeys, 8'hFF);

        // One-cycle glitch on key 7 must leave no trace.
        iKeys = 8'h7F;
        ticks(1);
        iKeys = 8'hFF;
        for (int g = 0; g < 8; g++) begin
            ticks(1);
            chk("glitchKeys", oKeys, 8'hFF);
            chk("glitchPulse", oPress | oRelease, 8'h00);
        end
        // A stale count would make this press land one edge early.
        iKeys = 8'h7F;
        ticks(5);
        chk("glitchCntClear", oKeys, 8'hFF);
        ticks(1);
        chk("glitchPressKeys", oKeys, 8'h7F);
        chk("glitchPressPulse", oPress, 8'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/key_debounce8.md
Name: key_debounce8

Overview:
- 8-key input conditioning stage that sits directly upstream of the 8-to-3 priority encoder.
- Synchronizes eight raw, asynchronous, active-low push-button lines to iClk and debounces each key independently.
- Drives a clean active-low key vector and an active-low encoder enable, wired straight into the encoder's iData/iEI.
- Also emits one-cycle press and release pulses per key for downstream event logic.

Parameters:
- DEBOUNCE_CYCLES, 4: number of consecutive stable synchronized samples needed to accept a key change. Must be >= 1. Default suits simulation; the board build overrides it, e.g. 1000000 at 100 MHz for 10 ms.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of each per-key stability counter. Derived; not overridden.

Ports:
- iClk  input  1  system clock, rising-edge active
- iRst  input  1  asynchronous, active-high reset
- iKeys  input  8  raw key lines, active-low (0 = pressed), asynchronous to iClk
- iEn  input  1  block enable, active-high
- oKeys  output  8  debounced key vector, active-low; feeds encoder iData
- oEI  output  1  encoder strobe enable, active-low; feeds encoder iEI
- oPress  output  8  one-cycle pulse per key on accepted press (1 -> 0)
- oRelease  output  8  one-cycle pulse per key on accepted release (0 -> 1)

Behaviour:
- Reset (async assert, sync deassert at the next iClk edge):
  - sync stages = 8'hFF, oKeys = 8'hFF, all counters = 0
  - oPress = 0, oRelease = 0, oEI = 1
- Synchronizer: 2-FF chain per bit, s1 <= iKeys, s2 <= s1. s2 is the only version of the keys used after this point.
- Per-key debounce, evaluated every edge for key i:
  - s2[i] == oKeys[i]: cnt[i] <= 0.
  - s2[i] != oKeys[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s2[i] != oKeys[i] and cnt[i] == DEBOUNCE_CYCLES-1: oKeys[i] <= s2[i] and cnt[i] <= 0.
- Latency: a clean raw edge that arrives before clock edge N shows on oKeys at edge N+1+DEBOUNCE_CYCLES. That is 2 sync cycles plus DEBOUNCE_CYCLES.
- Glitch rejection: a mismatch that lasts fewer than DEBOUNCE_CYCLES synchronized samples clears the counter and never changes oKeys. A bounce mid-count restarts the count from 0.
- Pulses: registered and asserted on the same edge that changes oKeys[i].
  - oPress[i] = 1 for exactly one cycle when oKeys[i] goes 1 -> 0.
  - oRelease[i] = 1 for exactly one cycle when oKeys[i] goes 0 -> 1.
  - Both are 0 on all other cycles.
  - Both are gated by iEn as sampled on that edge. If iEn = 0, no pulse is produced, but oKeys still updates.
- oEI: registered, oEI <= ~iEn, so there is one cycle of latency from iEn.
- Debouncing runs regardless of iEn.
- Keys are fully independent: simultaneous transitions on several keys each debounce on their own counters and may pulse on the same cycle.
- Reset mid-count: all state is lost and oKeys returns to 8'hFF. A key held down through reset is re-accepted 2+DEBOUNCE_CYCLES cycles after reset deasserts, with an oPress pulse if iEn = 1.
- Counters saturate structurally: they never exceed DEBOUNCE_CYCLES-1, so there is no wrap-around.
- DEBOUNCE_CYCLES = 1: a change is accepted on the first mismatching s2 sample (latency 3).

Decomposition:
- Shared package key_pkg:
  - NUM_KEYS = 8
  - KEY_PRESSED = 1'b0, KEY_RELEASED = 1'b1
  - default DEBOUNCE_CYCLES values for simulation and board
- One natural sub-module: key_debounce_bit, holding the 2-FF sync, the counter and the one-bit debounced state plus press/release pulses. It is instantiated 8 times via generate. The top level adds the iEn gating and the oEI register.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset: assert iRst mid-cycle with iKeys = 8'h00 -> oKeys = 8'hFF, oPress = 0, oRelease = 0, oEI = 1 immediately (async). After deassert with iEn = 1: oKeys = 8'h00 at 6 edges, oPress = 8'hFF for 1 cycle.
- Clean press: iEn = 1, iKeys[3] 1 -> 0 before edge N -> oKeys = 8'hF7 and oPress = 8'h08 at edge N+5, oPress = 0 at edge N+6. The encoder downstream then reads code 3'b100 with EO = 1.
- Bounce: iKeys[5] toggles 0/1/0/1 on 3-cycle periods, then held at 0 -> no change while toggling. oKeys[5] = 0 exactly 6 edges after the final stable transition, with a single oPress[5].
- Enable gating: iEn = 0, press key 0 -> oKeys = 8'hFE, oPress = 0, oEI = 1. Set iEn = 1 -> oEI = 0 one edge later, with no retroactive pulse.
- Simultaneous: keys 1 and 6 pressed on the same edge; 20 cycles later key 1 released -> oPress = 8'h42 on a single cycle. Later oRelease = 8'h02, and oKeys = 8'hBF afterwards.
- Glitch: 1-cycle low pulse on iKeys[7] -> oKeys stays 8'hFF, no pulses, and the internal counter returns to 0.
